// File: rtl/comparator_bist_if.sv
// Operand/flag bus between the BIST engine and the magnitude comparator under test.
// The master modport is the BIST side; the slave modport is the comparator side.
interface comparator_bist_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_gt;
    logic             dut_lt;
    logic             dut_eq;

    modport master (
        output dut_a,
        output dut_b,
        input  dut_gt,
        input  dut_lt,
        input  dut_eq
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        output dut_gt,
        output dut_lt,
        output dut_eq
    );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive built-in self-test for a WIDTH-bit magnitude comparator: sweeps every {A,B} pair,
// checks gt/lt/eq against an internal golden model, counts mismatches and keeps the first one.
module comparator_bist #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    comparator_bist_if.master  cmp,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [2*WIDTH:0]   err_count_o,
    output logic [WIDTH-1:0]   fail_a_o,
    output logic [WIDTH-1:0]   fail_b_o
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH:0]   err_q;
    logic [WIDTH-1:0]   fail_a_q;
    logic [WIDTH-1:0]   fail_b_q;
    logic               first_seen_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic               mismatch;
    logic               last_pair;

    // Any flag differing from the golden value counts, so non-one-hot flag sets are caught.
    assign mismatch  = (cmp.dut_gt != (a_q > b_q)) ||
                       (cmp.dut_lt != (a_q < b_q)) ||
                       (cmp.dut_eq != (a_q == b_q));
    assign last_pair = &{a_q, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            first_seen_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        a_q          <= '0;
                        b_q          <= '0;
                        cnt_q        <= '0;
                        err_q        <= '0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                        first_seen_q <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        cnt_q   <= '0;
                        state_q <= StCheck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (!first_seen_q) begin
                            first_seen_q <= 1'b1;
                            fail_a_q     <= a_q;
                            fail_b_q     <= b_q;
                        end
                    end
                    if (last_pair) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                        state_q <= StDone;
                    end else begin
                        // B is the low half of one 2*WIDTH-bit pair counter.
                        {a_q, b_q} <= {a_q, b_q} + 1'b1;
                        state_q    <= StSettle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmp.dut_a   = a_q;
    assign cmp.dut_b   = b_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_a_o    = fail_a_q;
    assign fail_b_o    = fail_b_q;

endmodule
